// File: rtl/ctrl_cfg_parser.sv
// Control-stream parser: turns module-addressed control packets into one-cycle table-write strobes.
// Optional malformed-packet counter enabled by defining CTRL_CFG_PARSER_STATS_EN.
module ctrl_cfg_parser #(
    parameter int         C_S_AXIS_DATA_WIDTH  = 256,
    parameter int         C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [4:0] STAGE_ID             = 5'd0,
    parameter int         IDX_WIDTH            = 8
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       ctrl_s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     ctrl_s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      ctrl_s_axis_tuser,
    input  logic                                 ctrl_s_axis_tvalid,
    input  logic                                 ctrl_s_axis_tlast,
    output logic                                 cfg_wr_en,
    output logic [3:0]                           cfg_res_id,
    output logic [IDX_WIDTH-1:0]                 cfg_addr,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       cfg_data,
    output logic [15:0]                          err_cnt
);

    // state      | meaning
    // ST_IDLE    | waiting for beat0 (Ethernet/IP header)
    // ST_HDR     | next beat is the control header
    // ST_PAYLOAD | each full beat is one table entry
    // ST_DROP    | discarding the rest of the packet
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [3:0]           res_id_q;
    logic [IDX_WIDTH-1:0] idx_q;

    logic                 wr_fire;
    logic                 hdr_accept;
    logic                 err_inc;
    logic                 keep_full;

    logic [4:0]           hdr_module_id;
    logic [3:0]           hdr_opcode;
    logic [3:0]           hdr_res_id;
    logic [IDX_WIDTH-1:0] hdr_idx;

    assign hdr_module_id = ctrl_s_axis_tdata[100:96];
    assign hdr_opcode    = ctrl_s_axis_tdata[107:104];
    assign hdr_res_id    = ctrl_s_axis_tdata[111:108];
    assign hdr_idx       = ctrl_s_axis_tdata[IDX_WIDTH+111:112];
    assign keep_full     = &ctrl_s_axis_tkeep;

    logic unused_tuser;
    assign unused_tuser = ^ctrl_s_axis_tuser;

    always_comb begin
        state_d    = state_q;
        wr_fire    = 1'b0;
        hdr_accept = 1'b0;
        err_inc    = 1'b0;
        if (ctrl_s_axis_tvalid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ctrl_s_axis_tlast) begin
                        err_inc = 1'b1;
                    end else begin
                        state_d = ST_HDR;
                    end
                end
                ST_HDR: begin
                    // A truncated header is an error even if it was addressed elsewhere.
                    if (ctrl_s_axis_tlast) begin
                        state_d = ST_IDLE;
                        err_inc = 1'b1;
                    end else if (hdr_module_id != STAGE_ID) begin
                        state_d = ST_DROP;
                    end else if (hdr_opcode != 4'h1) begin
                        state_d = ST_DROP;
                        err_inc = 1'b1;
                    end else begin
                        state_d    = ST_PAYLOAD;
                        hdr_accept = 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    if (keep_full) begin
                        wr_fire = 1'b1;
                        if (ctrl_s_axis_tlast) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        err_inc = 1'b1;
                        state_d = ctrl_s_axis_tlast ? ST_IDLE : ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (ctrl_s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            res_id_q   <= '0;
            idx_q      <= '0;
            cfg_wr_en  <= 1'b0;
            cfg_res_id <= '0;
            cfg_addr   <= '0;
            cfg_data   <= '0;
        end else begin
            state_q   <= state_d;
            cfg_wr_en <= wr_fire;
            if (hdr_accept) begin
                res_id_q <= hdr_res_id;
                idx_q    <= hdr_idx;
            end
            if (wr_fire) begin
                cfg_data   <= ctrl_s_axis_tdata;
                cfg_addr   <= idx_q;
                cfg_res_id <= res_id_q;
                idx_q      <= idx_q + 1'b1;
            end
        end
    end

`ifdef CTRL_CFG_PARSER_STATS_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            err_cnt_q <= '0;
        end else if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_inc;
    assign unused_err_inc = err_inc;
    assign err_cnt        = 16'd0;
`endif

endmodule

// File: tb/tb_ctrl_cfg_parser.sv
// Directed self-checking bench for ctrl_cfg_parser; expected err_cnt follows CTRL_CFG_PARSER_STATS_EN.
module tb_ctrl_cfg_parser;

    logic         clk = 1'b0;
    logic         aresetn;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic [127:0] tuser;
    logic         tvalid;
    logic         tlast;
    logic         cfg_wr_en;
    logic [3:0]   cfg_res_id;
    logic [7:0]   cfg_addr;
    logic [255:0] cfg_data;
    logic [15:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int exp_strobes = 0;
    logic [15:0] exp_err = 16'd0;

    localparam logic [31:0] KF = 32'hFFFF_FFFF;

    ctrl_cfg_parser dut (
        .clk                (clk),
        .aresetn            (aresetn),
        .ctrl_s_axis_tdata  (tdata),
        .ctrl_s_axis_tkeep  (tkeep),
        .ctrl_s_axis_tuser  (tuser),
        .ctrl_s_axis_tvalid (tvalid),
        .ctrl_s_axis_tlast  (tlast),
        .cfg_wr_en          (cfg_wr_en),
        .cfg_res_id         (cfg_res_id),
        .cfg_addr           (cfg_addr),
        .cfg_data           (cfg_data),
        .err_cnt            (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (aresetn === 1'b1 && cfg_wr_en === 1'b1) strobes++;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_err();
`ifdef CTRL_CFG_PARSER_STATS_EN
        exp_err = exp_err + 16'd1;
`endif
    endtask

    function automatic logic [255:0] hdr(input logic [4:0] mid, input logic [3:0] op,
                                         input logic [3:0] res, input logic [7:0] idx);
        logic [255:0] d;
        d = {8{32'h1357_9BDF}};
        d[100:96]  = mid;
        d[107:104] = op;
        d[111:108] = res;
        d[119:112] = idx;
        return d;
    endfunction

    task automatic beat(input logic [255:0] d, input logic [31:0] k, input logic l);
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tvalid = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic [3:0] res, input logic [7:0] addr,
                             input logic [255:0] d);
        exp_strobes++;
        chk({tag, "_wr"}, {255'd0, cfg_wr_en}, 256'd1);
        chk({tag, "_res"}, {252'd0, cfg_res_id}, {252'd0, res});
        chk({tag, "_addr"}, {248'd0, cfg_addr}, {248'd0, addr});
        chk({tag, "_data"}, cfg_data, d);
    endtask

    logic [255:0] b0, d1, d2, d3, d4;

    initial begin
        b0 = {8{32'hE0E0_0800}};
        d1 = {8{32'hDEAD_BEEF}};
        d2 = {4{64'h0123_4567_89AB_CDEF}};
        d3 = {16{16'hC3A5}};
        d4 = {2{128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878}};
        aresetn = 1'b0;
        tdata = '0; tkeep = '0; tuser = '1; tvalid = 1'b0; tlast = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_wr", {255'd0, cfg_wr_en}, 256'd0);
        chk("rst_res", {252'd0, cfg_res_id}, 256'd0);
        chk("rst_addr", {248'd0, cfg_addr}, 256'd0);
        chk("rst_data", cfg_data, 256'd0);
        chk("rst_err", {240'd0, err_cnt}, 256'd0);
        aresetn = 1'b1;
        idle(2);

        // Basic 3-beat packet: res 3, index 5
        beat(b0, KF, 1'b0);
        beat(hdr(5'd0, 4'h1, 4'd3, 8'd5), KF, 1'b0);
        chk("p1_hdr_nowr", {255'd0, cfg_wr_en}, 256'd0);
        beat(d1, KF, 1'b1);
        chk_write("p1", 4'd3, 8'd5, d1);
        idle(1);
        chk("p1_wr_low", {255'd0, cfg_wr_en}, 256'd0);
        chk("p1_data_hold", cfg_data, d1);
        chk("p1_addr_hold", {248'd0, cfg_addr}, 256'd5);

        // Index wrap FE, FF, 00 with back-to-back strobes
        beat(b0, KF, 1'b0);
        beat(hdr(5'd0, 4'h1, 4'd7, 8'hFE), KF, 1'b0);
        beat(d1, KF, 1'b0);
        chk_write("wrap0", 4'd7, 8'hFE, d1);
        beat(d2, KF, 1'b0);
        chk_write("wrap1", 4'd7, 8'hFF, d2);
        beat(d3, KF, 1'b1);
        chk_write("wrap2", 4'd7, 8'h00, d3);
        idle(1);
        chk("wrap_wr_low", {255'd0, cfg_wr_en}, 256'd0);

        // Foreign module id: silently dropped
        beat(b0, KF, 1'b0);
        beat(hdr(5'd1, 4'h1, 4'd2, 8'h10), KF, 1'b0);
        beat(d4, KF, 1'b0);
        beat(d4, KF, 1'b1);
        idle(1);
        chk("foreign_strobes", strobes, exp_strobes);
        chk("foreign_err", {240'd0, err_cnt}, {240'd0, exp_err});
        chk("foreign_data_hold", cfg_data, d3);
        beat(b0, KF, 1'b0);
        beat(hdr(5'd0, 4'h1, 4'd2, 8'h10), KF, 1'b0);
        beat(d4, KF, 1'b1);
        chk_write("after_foreign", 4'd2, 8'h10, d4);

        // Partial tkeep mid-packet drops the remainder
        beat(b0, KF, 1'b0);
        beat(hdr(5'd0, 4'h1, 4'd1, 8'h20), KF, 1'b0);
        beat(d1, KF, 1'b0);
        chk_write("keep_first", 4'd1, 8'h20, d1);
        beat(d2, 32'h0000_FFFF, 1'b0);
        expect_err();
        chk("keep_bad_nowr", {255'd0, cfg_wr_en}, 256'd0);
        beat(d3, KF, 1'b0);
        beat(d4, KF, 1'b1);
        idle(1);
        chk("keep_strobes", strobes, exp_strobes);
        chk("keep_err", {240'd0, err_cnt}, {240'd0, exp_err});
        chk("keep_addr_hold", {248'd0, cfg_addr}, 256'h20);

        // tvalid gaps of 3 cycles between beats
        beat(b0, KF, 1'b0);
        idle(3);
        beat(hdr(5'd0, 4'h1, 4'd5, 8'h40), KF, 1'b0);
        idle(3);
        beat(d2, KF, 1'b0);
        chk_write("gap0", 4'd5, 8'h40, d2);
        idle(1);
        chk("gap_wr_low", {255'd0, cfg_wr_en}, 256'd0);
        idle(2);
        beat(d3, KF, 1'b1);
        chk_write("gap1", 4'd5, 8'h41, d3);

        // Malformed headers
        beat(d1, KF, 1'b1);
        expect_err();
        beat(b0, KF, 1'b0);
        beat(hdr(5'd0, 4'h1, 4'd6, 8'h60), KF, 1'b1);
        expect_err();
        beat(b0, KF, 1'b0);
        beat(hdr(5'd0, 4'h2, 4'd6, 8'h60), KF, 1'b0);
        expect_err();
        beat(d4, KF, 1'b1);
        idle(1);
        chk("badhdr_strobes", strobes, exp_strobes);
        chk("badhdr_err", {240'd0, err_cnt}, {240'd0, exp_err});

        // Reset mid-packet after the header
        beat(b0, KF, 1'b0);
        beat(hdr(5'd0, 4'h1, 4'd4, 8'h50), KF, 1'b0);
        aresetn = 1'b0;
        exp_err = 16'd0;
        #2;
        chk("mid_rst_data", cfg_data, 256'd0);
        chk("mid_rst_addr", {248'd0, cfg_addr}, 256'd0);
        chk("mid_rst_err", {240'd0, err_cnt}, 256'd0);
        @(posedge clk);
        #2;
        aresetn = 1'b1;
        idle(1);
        beat(d1, KF, 1'b0);
        chk("post_rst_beat0_nowr", {255'd0, cfg_wr_en}, 256'd0);
        beat(hdr(5'd0, 4'h1, 4'd9, 8'h33), KF, 1'b0);
        beat(d4, KF, 1'b1);
        chk_write("post_rst", 4'd9, 8'h33, d4);
        idle(2);
        chk("final_strobes", strobes, exp_strobes);
        chk("final_err", {240'd0, err_cnt}, {240'd0, exp_err});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_cfg_parser.md
CTRL_CFG_PARSER -- requirements
Module: ctrl_cfg_parser

Interface
REQ-001 C_S_AXIS_DATA_WIDTH, 256: control stream data width; only 256 is supported.
REQ-002 C_S_AXIS_TUSER_WIDTH, 128: tuser width; tuser is accepted and ignored.
REQ-003 STAGE_ID, 0: 5-bit module ID this instance answers to.
REQ-004 IDX_WIDTH, 8: entry index width.
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 aresetn  in  1  reset; asynchronous, active-low.
REQ-007 ctrl_s_axis_tdata  in  256  control beat data.
REQ-008 ctrl_s_axis_tkeep  in  32  byte enables.
REQ-009 ctrl_s_axis_tuser  in  128  unused.
REQ-010 ctrl_s_axis_tvalid  in  1  beat valid; there is no tready and every valid beat is consumed.
REQ-011 ctrl_s_axis_tlast  in  1  last beat of packet.
REQ-012 cfg_wr_en  out  1  one-cycle table-write strobe.
REQ-013 cfg_res_id  out  4  target resource within the stage.
REQ-014 cfg_addr  out  IDX_WIDTH  entry index.
REQ-015 cfg_data  out  256  entry data.
REQ-016 err_cnt  out  16  malformed-packet counter.

Function
REQ-017 Packet layout:
- beat0: Ethernet/IP header, ignored.
- beat1 control header: tdata[100:96] module_id, tdata[107:104] opcode, tdata[111:108] res_id, tdata[IDX_WIDTH+111:112] start index.
- beat2 onward: one entry per beat.
REQ-018 States are IDLE, HDR, PAYLOAD and DROP; a cycle with tvalid=0 holds the current state and registers.
REQ-019 IDLE: a valid beat with tlast=0 -> HDR; a valid beat with tlast=1 -> stay IDLE, err_cnt+1.
REQ-020 HDR, valid beat:
- tlast=1 -> IDLE, err_cnt+1.
- module_id!=STAGE_ID -> DROP, no error.
- opcode!=4'h1 -> DROP, err_cnt+1.
- otherwise -> latch res_id and index, go to PAYLOAD.
REQ-021 PAYLOAD, valid beat with tkeep=32'hFFFFFFFF: the next cycle drives cfg_wr_en=1 with cfg_data=tdata, cfg_addr=current index and cfg_res_id=latched value; then index+1.
REQ-022 Index increments modulo 2^IDX_WIDTH; all-ones wraps to 0.
REQ-023 PAYLOAD, valid beat with tkeep not all-ones: no write, err_cnt+1, -> DROP if tlast=0, else -> IDLE.
REQ-024 PAYLOAD, valid beat with tlast=1 (full tkeep): write issued, -> IDLE.
REQ-025 DROP: consume beats; a valid beat with tlast=1 -> IDLE.
REQ-026 Latency is exactly 1 cycle from beat to cfg_wr_en; back-to-back beats give back-to-back strobes.
REQ-027 cfg_wr_en is 0 in every cycle not covered by REQ-021.
REQ-028 cfg_data, cfg_addr and cfg_res_id hold their last values between strobes.
REQ-029 err_cnt saturates at 16'hFFFF.
REQ-030 REQ-023 takes precedence when tkeep and tlast errors coincide; err_cnt increments at most 1 per beat.

Reset
REQ-031 aresetn=0 immediately forces state=IDLE and sets all outputs, the latched index and err_cnt to 0.
REQ-032 A reset mid-packet discards the packet; the first valid beat after release is treated as beat0.

Configuration
REQ-033 Macro CTRL_CFG_PARSER_STATS_EN:
- defined: err_cnt is implemented per REQ-019 to REQ-030.
- undefined: no counter logic; err_cnt is constant 0 and all other behaviour is unchanged.

Verification
REQ-034 3-beat packet, module_id=STAGE_ID, opcode=1, res_id=3, index=5, beat2 data=D -> one strobe 1 cycle after beat2: res 3, addr 5, data D.
REQ-035 5-beat packet, index=8'hFE, IDX_WIDTH=8 -> three strobes with addr FE, FF, 00.
REQ-036 module_id=STAGE_ID+1 -> no strobe, err_cnt unchanged, the next valid packet is written.
REQ-037 Payload beat with tkeep=32'h0000FFFF mid-packet -> no write for the rest of the packet, err_cnt+1.
REQ-038 tvalid gaps of 3 cycles between beats -> same writes as the gap-free run, with strobe timing shifted.
REQ-039 aresetn pulsed low after beat1 -> no strobe and all outputs 0; the next full packet is written correctly.
